nav_msg_gen: RTL

Navigation-message bit source for the GPS signal generator. Counts C/A chip strobes into 1023-chip code epochs and 20-epoch data bits, and presents one data bit per bit period to the core's message selector. Data comes from a small serial-loaded bit FIFO (live message) or a built-in 8-bit looping preset. Sits directly upstream of the generator core, clocked by the same clock and chip strobe.

---
 rtl/gps_gen_pkg.sv | 35 +++
 rtl/msg_bit_fifo.sv | 80 ++++++++
 rtl/nav_msg_gen.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/gps_gen_pkg.sv
// rtl/gps_gen_pkg.sv - shared constants, state encoding and preset patterns for the GPS generator
//
// Contents:
//   DEF_CHIPS_PER_EPOCH / DEF_EPOCHS_PER_BIT / DEF_MSG_FIFO_DEPTH - default geometry
//   PRESET_*       - 8-bit looping message patterns, sent MSB first
//   nav_state_e    - message generator state encoding
//   preset_pattern - maps a 2-bit preset select onto its pattern
package gps_gen_pkg;

    localparam int DEF_CHIPS_PER_EPOCH = 1023;
    localparam int DEF_EPOCHS_PER_BIT  = 20;
    localparam int DEF_MSG_FIFO_DEPTH  = 8;

    localparam logic [7:0] PRESET_TLM   = 8'h8B;  // TLM preamble
    localparam logic [7:0] PRESET_ALT   = 8'hAA;
    localparam logic [7:0] PRESET_ONES  = 8'hFF;
    localparam logic [7:0] PRESET_ZEROS = 8'h00;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } nav_state_e;

    function automatic logic [7:0] preset_pattern(input logic [1:0] sel);
        logic [7:0] pat;
        case (sel)
            2'd0:    pat = PRESET_TLM;
            2'd1:    pat = PRESET_ALT;
            2'd2:    pat = PRESET_ONES;
            default: pat = PRESET_ZEROS;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/msg_bit_fifo.sv
// rtl/msg_bit_fifo.sv - depth-parameterised 1-bit FIFO with registered occupancy and flags
//
// Ports:
//   clk_i, rst_i  - clock, synchronous active-high reset (flushes the FIFO)
//   push_i        - write push_data_i this cycle
//   push_data_i   - bit to store
//   pop_i         - consume the head this cycle (ignored when empty)
//   pop_data_o    - current head bit
//   full_o        - registered: occupancy == DEPTH
//   empty_o       - registered: occupancy == 0
//   drop_o        - combinational: a push is being discarded this cycle
module msg_bit_fifo #(
    parameter int DEPTH = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  logic push_data_i,
    input  logic pop_i,
    output logic pop_data_o,
    output logic full_o,
    output logic empty_o,
    output logic drop_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0] mem_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             full_q;
    logic             empty_q;
    logic             do_push;
    logic             do_pop;

    // A pop frees a slot in the same cycle, so a push into a full FIFO is
    // still accepted when it coincides with a pop. A pop on an empty FIFO
    // does nothing, even if a push lands in the same cycle.
    always_comb begin
        do_pop  = pop_i && !empty_q;
        do_push = push_i && (!full_q || do_pop);
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign full_o     = full_q;
    assign empty_o    = empty_q;
    assign drop_o     = push_i && full_q && !do_pop;

endmodule

// File: rtl/nav_msg_gen.sv
// rtl/nav_msg_gen.sv - navigation message bit source: chip/epoch counting and bit loading
//
// Ports:
//   clk_in, rst_in     - clock, synchronous active-high reset
//   ena_in             - chip strobe, one cycle per chip
//   msg_in             - live message bit
//   msg_valid_in       - push msg_in into the bit FIFO
//   use_msg_preset_in  - 1: preset pattern, 0: FIFO (sampled at bit load)
//   preset_sel_in      - preset pattern select (sampled at bit load)
//   msg_bit_out        - current data bit
//   bit_start_out      - pulse on the first chip of a new bit
//   epoch_out          - pulse on the first chip of every epoch
//   fifo_full_out      - FIFO full
//   fifo_empty_out     - FIFO empty
//   underrun_out       - sticky: a FIFO bit was needed while empty
//   overflow_out       - sticky: a push was dropped because the FIFO was full
module nav_msg_gen
    import gps_gen_pkg::*;
#(
    parameter int CHIPS_PER_EPOCH = DEF_CHIPS_PER_EPOCH,
    parameter int EPOCHS_PER_BIT  = DEF_EPOCHS_PER_BIT,
    parameter int FIFO_DEPTH      = DEF_MSG_FIFO_DEPTH
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       ena_in,
    input  logic       msg_in,
    input  logic       msg_valid_in,
    input  logic       use_msg_preset_in,
    input  logic [1:0] preset_sel_in,
    output logic       msg_bit_out,
    output logic       bit_start_out,
    output logic       epoch_out,
    output logic       fifo_full_out,
    output logic       fifo_empty_out,
    output logic       underrun_out,
    output logic       overflow_out
);

    localparam int CHIP_W  = (CHIPS_PER_EPOCH > 1) ? $clog2(CHIPS_PER_EPOCH) : 1;
    localparam int EPOCH_W = (EPOCHS_PER_BIT > 1) ? $clog2(EPOCHS_PER_BIT) : 1;
    localparam logic [CHIP_W-1:0]  LAST_CHIP  = CHIP_W'(CHIPS_PER_EPOCH - 1);
    localparam logic [EPOCH_W-1:0] LAST_EPOCH = EPOCH_W'(EPOCHS_PER_BIT - 1);

    nav_state_e         state_q, state_d;
    logic [CHIP_W-1:0]  chip_q, chip_d;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;
    logic [2:0]         idx_q, idx_d;
    logic               bit_q, bit_d;
    logic               bit_start_q, bit_start_d;
    logic               epoch_pulse_q, epoch_pulse_d;
    logic               underrun_q, underrun_d;
    logic               overflow_q, overflow_d;

    logic               load;
    logic [7:0]         pattern;
    logic               fifo_pop;
    logic               fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_drop;

    msg_bit_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_in),
        .rst_i       (rst_in),
        .push_i      (msg_valid_in),
        .push_data_i (msg_in),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .drop_o      (fifo_drop)
    );

    // The position is the index of the strobe just consumed. The first
    // strobe out of IDLE is position (0,0) and loads bit 0, so every bit
    // (including the first) spans exactly C*E strobes.
    always_comb begin
        state_d       = state_q;
        chip_d        = chip_q;
        epoch_d       = epoch_q;
        idx_d         = idx_q;
        bit_d         = bit_q;
        underrun_d    = underrun_q;
        load          = 1'b0;
        epoch_pulse_d = 1'b0;
        fifo_pop      = 1'b0;
        pattern       = preset_pattern(preset_sel_in);

        case (state_q)
            ST_IDLE: begin
                if (ena_in) begin
                    state_d       = ST_RUN;
                    chip_d        = '0;
                    epoch_d       = '0;
                    load          = 1'b1;
                    epoch_pulse_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (ena_in) begin
                    if (chip_q == LAST_CHIP) begin
                        chip_d        = '0;
                        epoch_pulse_d = 1'b1;
                        if (epoch_q == LAST_EPOCH) begin
                            epoch_d = '0;
                            load    = 1'b1;
                        end else begin
                            epoch_d = epoch_q + EPOCH_W'(1);
                        end
                    end else begin
                        chip_d = chip_q + CHIP_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        bit_start_d = load;

        // Mode and preset select only matter here, so mid-bit changes wait
        // for the next load. idx only moves on preset loads and survives
        // mode switches.
        if (load) begin
            if (use_msg_preset_in) begin
                bit_d = pattern[3'd7 - idx_q];
                idx_d = idx_q + 3'd1;
            end else if (!fifo_empty) begin
                bit_d    = fifo_head;
                fifo_pop = 1'b1;
            end else begin
                bit_d      = 1'b0;
                underrun_d = 1'b1;
            end
        end
    end

    // Kept apart from the block above: fifo_drop depends on fifo_pop.
    assign overflow_d = overflow_q | fifo_drop;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q       <= ST_IDLE;
            chip_q        <= '0;
            epoch_q       <= '0;
            idx_q         <= '0;
            bit_q         <= 1'b0;
            bit_start_q   <= 1'b0;
            epoch_pulse_q <= 1'b0;
            underrun_q    <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            chip_q        <= chip_d;
            epoch_q       <= epoch_d;
            idx_q         <= idx_d;
            bit_q         <= bit_d;
            bit_start_q   <= bit_start_d;
            epoch_pulse_q <= epoch_pulse_d;
            underrun_q    <= underrun_d;
            overflow_q    <= overflow_d;
        end
    end

    assign msg_bit_out    = bit_q;
    assign bit_start_out  = bit_start_q;
    assign epoch_out      = epoch_pulse_q;
    assign fifo_full_out  = fifo_full;
    assign fifo_empty_out = fifo_empty;
    assign underrun_out   = underrun_q;
    assign overflow_out   = overflow_q;

endmodule
